// File: rtl/serial_operand_loader_if.sv
// Operand-pair bus between the bit-serial front end and the multiplier stage.
// Latency: n/a (wiring only); carries serial input, frame control and the output pair.
// Backpressure: VALID/READY on the pair; a pair arriving while one is held is dropped (OVF).
interface serial_operand_loader_if #(
    parameter int WIDTH = 32
);
    logic             SIN;
    logic             SEN;
    logic             SYNC;
    logic [WIDTH-1:0] A_OUT;
    logic [WIDTH-1:0] B_OUT;
    logic             VALID;
    logic             READY;
    logic             OVF;
    logic             OVF_CLR;

    // Upstream/downstream side: drives the stream and READY, observes the pair.
    modport master (
        output SIN, SEN, SYNC, READY, OVF_CLR,
        input  A_OUT, B_OUT, VALID, OVF
    );

    // Loader side.
    modport slave (
        input  SIN, SEN, SYNC, READY, OVF_CLR,
        output A_OUT, B_OUT, VALID, OVF
    );
endinterface

// File: rtl/serial_operand_loader.sv
// Assembles an LSB-first serial stream into {A, B} operand pairs for the multiplier.
// Latency: VALID rises on the edge that samples the last bit of B (visible the cycle after).
// Backpressure: pair held until VALID&&READY; a completed pair that cannot be loaded is dropped and OVF set.
module serial_operand_loader #(
    parameter int WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    serial_operand_loader_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {COLLECT_A = 1'b0, COLLECT_B = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_stage_q, a_stage_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] word;
    logic             pair_done;
    logic             drop;

    // The word completing this cycle includes the bit being sampled right now.
    assign word = {bus.SIN, sreg_q[WIDTH-1:1]};

    // Next-state: framing FSM, output-register load/consume, sticky overflow.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        a_stage_d = a_stage_q;
        a_out_d   = a_out_q;
        b_out_d   = b_out_q;
        valid_d   = valid_q;
        pair_done = 1'b0;
        drop      = 1'b0;

        if (bus.SYNC) begin
            // Restart framing; a bit sampled alongside SYNC is bit 0 of a fresh A.
            state_d   = COLLECT_A;
            a_stage_d = '0;
            cnt_d     = '0;
            if (bus.SEN) begin
                sreg_d = word;
                cnt_d  = CW'(1);
            end
        end else if (bus.SEN) begin
            sreg_d = word;
            if (cnt_q == LAST) begin
                cnt_d = '0;
                if (state_q == COLLECT_A) begin
                    a_stage_d = word;
                    state_d   = COLLECT_B;
                end else begin
                    state_d   = COLLECT_A;
                    pair_done = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (pair_done) begin
            // Load is allowed if the register is empty or being drained this same cycle.
            if (!valid_q || bus.READY) begin
                a_out_d = a_stage_q;
                b_out_d = word;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && bus.READY) begin
            valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop ? 1'b1 : (bus.OVF_CLR ? 1'b0 : ovf_q);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= COLLECT_A;
            sreg_q    <= '0;
            cnt_q     <= '0;
            a_stage_q <= '0;
            a_out_q   <= '0;
            b_out_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            a_stage_q <= a_stage_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.A_OUT = a_out_q;
    assign bus.B_OUT = b_out_q;
    assign bus.VALID = valid_q;
    assign bus.OVF   = ovf_q;
endmodule

// File: tb/tb_serial_operand_loader.sv
// Self-checking bench for serial_operand_loader (WIDTH=32).
// Latency: checks VALID the cycle after the final bit edge.
// Backpressure: exercises held pairs, drops/OVF, and the READY drain path.
module tb_serial_operand_loader;
    localparam int W = 32;

    logic CLK;
    logic RESET_N;
    int   checks;
    int   errors;
    int   cyc;
    int   hs_cnt;
    int   hs_cycle [8];
    logic [W-1:0] hs_a [8];
    logic [W-1:0] hs_b [8];

    serial_operand_loader_if #(.WIDTH(W)) bus ();

    serial_operand_loader #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Handshake monitor: records every accepted pair and the cycle it was accepted on.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (bus.VALID && bus.READY) begin
            if (hs_cnt < 8) begin
                hs_cycle[hs_cnt] = cyc;
                hs_a[hs_cnt]     = bus.A_OUT;
                hs_b[hs_cnt]     = bus.B_OUT;
            end
            hs_cnt = hs_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Serialise {B,A} LSB-first; optional SYNC on bit 0, random SEN gaps, pre-last VALID check.
    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit sync_first, input int gap_max, input bit check_pre);
        logic [2*W-1:0] fr;
        int gap;
        fr = {b, a};
        for (int i = 0; i < 2*W; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) tick();
            if (check_pre && i == 2*W-1) check("valid_before_last_bit", 64'(bus.VALID), 64'd0);
            bus.SIN  = fr[i];
            bus.SEN  = 1'b1;
            bus.SYNC = sync_first && (i == 0);
            tick();
            bus.SEN  = 1'b0;
            bus.SYNC = 1'b0;
        end
    endtask

    task automatic send_garbage(input int n);
        for (int i = 0; i < n; i++) begin
            bus.SIN = ((i % 3) == 0);
            bus.SEN = 1'b1;
            tick();
        end
        bus.SEN = 1'b0;
    endtask

    task automatic check_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        check({tag, "_valid"}, 64'(bus.VALID), 64'd1);
        check({tag, "_a"}, 64'(bus.A_OUT), 64'(a));
        check({tag, "_b"}, 64'(bus.B_OUT), 64'(b));
    endtask

    task automatic drain();
        bus.READY = 1'b1;
        tick();
        bus.READY = 1'b0;
        check("drain_valid_low", 64'(bus.VALID), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        logic         exp_valid;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [3];

    initial begin
        checks = 0; errors = 0; cyc = 0; hs_cnt = 0;
        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};

        bus.SIN = 0; bus.SEN = 0; bus.SYNC = 0; bus.READY = 0; bus.OVF_CLR = 0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_valid", 64'(bus.VALID), 64'd0);
        check("reset_ovf", 64'(bus.OVF), 64'd0);
        check("reset_a", 64'(bus.A_OUT), 64'd0);
        check("reset_b", 64'(bus.B_OUT), 64'd0);
        RESET_N = 1'b1;
        tick();

        // Single frame held under READY=0, then consumed.
        send_frame(32'h3F80_0000, 32'h4000_0000, 1'b0, 0, 1'b1);
        check_pair("t1", 32'h3F80_0000, 32'h4000_0000);
        check("t1_ovf", 64'(bus.OVF), 64'd0);
        repeat (5) tick();
        check_pair("t1_hold", 32'h3F80_0000, 32'h4000_0000);
        drain();

        // Back-to-back frames with READY tied high.
        bus.READY = 1'b1;
        hs_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send_frame(vecs[k].a, vecs[k].b, 1'b0, 0, 1'b0);
            check($sformatf("t2_valid_%0d", k), 64'(bus.VALID), 64'(vecs[k].exp_valid));
            check($sformatf("t2_a_%0d", k), 64'(bus.A_OUT), 64'(vecs[k].exp_a));
            check($sformatf("t2_b_%0d", k), 64'(bus.B_OUT), 64'(vecs[k].exp_b));
            check($sformatf("t2_ovf_%0d", k), 64'(bus.OVF), 64'(vecs[k].exp_ovf));
        end
        tick();
        check("t2_pulse_end", 64'(bus.VALID), 64'd0);
        check("t2_hs_count", 64'(hs_cnt), 64'd3);
        check("t2_spacing_01", 64'(hs_cycle[1] - hs_cycle[0]), 64'd64);
        check("t2_spacing_12", 64'(hs_cycle[2] - hs_cycle[1]), 64'd64);
        check("t2_hs_b2", 64'(hs_b[2]), 64'h7FFF_FFFF);
        bus.READY = 1'b0;

        // Overflow: second pair dropped while first is held.
        send_frame(32'h1111_1111, 32'h2222_2222, 1'b0, 0, 1'b0);
        send_frame(32'h3333_3333, 32'h4444_4444, 1'b0, 0, 1'b0);
        check_pair("t3_retained", 32'h1111_1111, 32'h2222_2222);
        check("t3_ovf_set", 64'(bus.OVF), 64'd1);
        bus.OVF_CLR = 1'b1;
        tick();
        bus.OVF_CLR = 1'b0;
        check("t3_ovf_clr", 64'(bus.OVF), 64'd0);
        check_pair("t3_after_clr", 32'h1111_1111, 32'h2222_2222);
        drain();

        // SYNC with SEN low after a partial frame.
        send_garbage(20);
        bus.SYNC = 1'b1;
        tick();
        bus.SYNC = 1'b0;
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, 1'b0);
        check_pair("t4_sync", 32'h1234_5678, 32'h9ABC_DEF0);
        drain();

        // SYNC together with bit 0.
        send_garbage(20);
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b0);
        check_pair("t4_sync_sen", 32'h1234_5678, 32'h9ABC_DEF0);

        // Asynchronous reset mid-frame while a pair is held.
        send_garbage(50);
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        check("t5_valid", 64'(bus.VALID), 64'd0);
        check("t5_ovf", 64'(bus.OVF), 64'd0);
        check("t5_a", 64'(bus.A_OUT), 64'd0);
        check("t5_b", 64'(bus.B_OUT), 64'd0);
        tick();
        RESET_N = 1'b1;
        tick();
        send_frame(32'd5, 32'd7, 1'b0, 0, 1'b0);
        check_pair("t5_after", 32'd5, 32'd7);
        drain();

        // Random SEN gaps.
        send_frame(32'hC049_0FDB, 32'h3EAA_AAAB, 1'b0, 5, 1'b1);
        check_pair("t6_gaps", 32'hC049_0FDB, 32'h3EAA_AAAB);
        check("t6_ovf", 64'(bus.OVF), 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
